// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and iteration-count helper for seq_alu
package alu_pkg;
  localparam logic [2:0] ALU_FWD  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_MULT = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_ROR  = 3'b111;
  typedef enum logic {IDLE, CALC} state_t;
  function automatic int unsigned iter_n(input logic [2:0] op, input int unsigned amt, input int unsigned width);
    return op == ALU_MULT ? width :
           (op == ALU_SLL || op == ALU_SRA) ? (amt < width ? amt : width) :
           op == ALU_ROR ? amt % width : 0;
  endfunction
endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: latched operands, accumulator and one-step shift/rotate/shift-add datapath
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, acc, nxt;
  always_comb begin
    nxt = op_r == ALU_MULT ? acc + (b_r[0] ? a_r : '0) :
          op_r == ALU_SLL  ? acc << 1 :
          op_r == ALU_SRA  ? {acc[WIDTH-1], acc[WIDTH-1:1]} :
                             {acc[0], acc[WIDTH-1:1]};
    y   = op_r[2]          ? acc :
          op_r == ALU_FWD  ? b_r :
          op_r == ALU_ADD  ? a_r + b_r :
          op_r == ALU_AND  ? a_r & b_r : a_r | b_r;
  end
  always_ff @(posedge clk) begin
    if (load) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
      acc  <= op == ALU_MULT ? '0 : a;
    end else if (step) begin
      a_r  <= a_r << 1;
      b_r  <= b_r >> 1;
      acc  <= nxt;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/done handshake and registered RESULT/ZERO
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] y;
  logic             load, step;
  assign load = state == IDLE && START && !RESET;
  assign step = state == CALC && cnt != '0;
  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk (CLK),
    .load(load),
    .step(step),
    .op  (SELECT),
    .a   (DATA1),
    .b   (DATA2),
    .y   (y)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      RESULT <= '0;
      ZERO   <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else if (state == IDLE) begin
      DONE <= 1'b0;
      if (START) begin
        state <= CALC;
        BUSY  <= 1'b1;
        cnt   <= CNT_W'(iter_n(SELECT, 32'(DATA2), WIDTH));
      end
    end else if (cnt == '0) begin
      state  <= IDLE;
      RESULT <= y;
      ZERO   <= y == '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8
module tb_seq_alu;
  logic       clk, rst, start;
  logic [2:0] sel;
  logic [7:0] d1, d2, result;
  logic       zero, busy, done;
  int         checks = 0, failures = 0;
  seq_alu #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .START (start),
    .SELECT(sel),
    .DATA1 (d1),
    .DATA2 (d2),
    .RESULT(result),
    .ZERO  (zero),
    .BUSY  (busy),
    .DONE  (done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1; sel = op; d1 = a; d2 = b;
    @(posedge clk); #1;
    start = 0; d1 = ~a; d2 = ~b; sel = ~op;
  endtask
  task automatic wait_done(output int lat, output int busy_cnt, output logic held);
    logic [7:0] prev;
    prev = result; lat = 0; busy_cnt = 0; held = 1;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (result !== prev) held = 0;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_r, input int exp_l);
    int lat, bc;
    logic held;
    issue(op, a, b);
    wait_done(lat, bc, held);
    check({tag, " latency"}, lat, exp_l);
    check({tag, " result"}, result, exp_r);
    check({tag, " zero"}, zero, exp_r == 0);
    check({tag, " busy cycles"}, bc, exp_l);
    check({tag, " busy low at done"}, busy, 0);
    check({tag, " result held"}, held, 1);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 0);
  endtask
  initial begin
    int lat, bc, dones;
    logic held;
    logic [7:0] got;
    rst = 1; start = 0; sel = 0; d1 = 0; d2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result, 0);
    check("reset zero", zero, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk); rst = 0;
    run("add", 3'b001, 8'h05, 8'h03, 8'h08, 1);
    run("add wrap", 3'b001, 8'h01, 8'hFF, 8'h00, 1);
    run("fwd", 3'b000, 8'h00, 8'h5A, 8'h5A, 1);
    run("mult", 3'b100, 8'hFD, 8'h05, 8'hF1, 9);
    run("sra3", 3'b110, 8'h80, 8'd3, 8'hF0, 4);
    run("sra200", 3'b110, 8'h80, 8'd200, 8'hFF, 9);
    run("sll1", 3'b101, 8'h81, 8'd1, 8'h02, 2);
    run("ror9", 3'b111, 8'h81, 8'd9, 8'hC0, 2);
    run("and", 3'b010, 8'h3C, 8'h0F, 8'h0C, 1);
    issue(3'b100, 8'hFD, 8'h05);
    dones = 0; got = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) begin dones++; got = result; end
      @(negedge clk);
      start = (k == 2); sel = 3'b010; d1 = 8'h0F; d2 = 8'hF0;
      @(posedge clk); #1;
    end
    check("dropped start dones", dones, 1);
    check("dropped start result", got, 8'hF1);
    issue(3'b100, 8'h07, 8'h03);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("abort result", result, 0);
    check("abort zero", zero, 1);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    @(negedge clk); rst = 0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort no done", dones, 0);
    run("or", 3'b011, 8'h0A, 8'h05, 8'h0F, 1);
    issue(3'b101, 8'h81, 8'd1);
    wait_done(lat, bc, held);
    check("b2b sll latency", lat, 2);
    check("b2b sll result", result, 8'h02);
    issue(3'b001, 8'h05, 8'h03);
    wait_done(lat, bc, held);
    check("b2b add latency", lat, 1);
    check("b2b add result", result, 8'h08);
    check("b2b add zero", zero, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
